puf_majority_voter: RTL and testbench

Upstream conditioning stage for the PUF signature error-correction block. Repeatedly samples the raw PUF response for one IP ID, then majority-votes each bit across an odd number of samples. Presents the stabilised signature on the `pcm_puf_in` / `pcm_puf_in_valid` / `pcm_ipid_number` lines the corrector consumes. Also reports how many bits were unstable, so firmware can judge PUF health before provisioning.

---
 rtl/mcse_puf_pkg.sv | 47 ++++
 rtl/puf_majority_voter_bit_vote_counter.sv | 52 +++++
 rtl/puf_majority_voter.sv | 221 ++++++++++++++++++++++
 tb/tb_puf_majority_voter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcse_puf_pkg.sv
// -----------------------------------------------------------------------------
// mcse_puf_pkg
// Shared definitions for the PUF majority-voter conditioning stage:
//   - voter_state_t : FSM state encoding for puf_majority_voter
//   - VOTE_CNT_W / UNSTABLE_W : widths for the default configuration
//   - vote_cnt_w(), unstable_w() : the same widths for any parameterisation
//   - vote_count_legal() : elaboration-time legality test for VOTE_COUNT
// Also supplies fallback values for the IPID_WIDTH / IPID_N macros when the
// surrounding build does not define them.
// -----------------------------------------------------------------------------
`ifndef IPID_WIDTH
`define IPID_WIDTH 32
`endif
`ifndef IPID_N
`define IPID_N 4
`endif

package mcse_puf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_VOTE = 3'd3,
        ST_HOLD = 3'd4
    } voter_state_t;

    localparam int DEFAULT_VOTE_COUNT = 5;
    localparam int VOTE_CNT_W = $clog2(DEFAULT_VOTE_COUNT + 1);
    localparam int UNSTABLE_W = $clog2(`IPID_WIDTH + 1);

    // Per-bit "ones" counter must hold 0..n inclusive.
    function automatic int vote_cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    // Unstable-bit count must hold 0..len inclusive.
    function automatic int unstable_w(input int len);
        return $clog2(len + 1);
    endfunction

    // Odd so a strict majority always exists; bounded so the counter stays 4 bits.
    function automatic bit vote_count_legal(input int n);
        return ((n % 2) == 1) && (n >= 3) && (n <= 15);
    endfunction

endpackage

// File: rtl/puf_majority_voter_bit_vote_counter.sv
// -----------------------------------------------------------------------------
// bit_vote_counter
// Counts how many of the collected samples had this signature bit set.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   clr             : clear the count (start of a new vote)
//   inc_en          : a valid sample is being accepted this cycle
//   sample_bit      : this bit of the accepted sample
//   vote_bit        : majority decision (count > VOTE_COUNT/2)
//   unstable        : samples disagreed (0 < count < VOTE_COUNT)
// -----------------------------------------------------------------------------
module bit_vote_counter
    import mcse_puf_pkg::*;
#(
    parameter int VOTE_COUNT = 5,
    parameter int CNT_W      = vote_cnt_w(VOTE_COUNT)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc_en,
    input  logic sample_bit,
    output logic vote_bit,
    output logic unstable
);

    logic [CNT_W-1:0] ones_q;
    logic [CNT_W-1:0] ones_d;

    // The FSM accepts exactly VOTE_COUNT samples between clears, so the
    // increment can never wrap.
    always_comb begin
        ones_d = ones_q;
        if (clr) begin
            ones_d = '0;
        end else if (inc_en && sample_bit) begin
            ones_d = ones_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ones_q <= '0;
        end else begin
            ones_q <= ones_d;
        end
    end

    assign vote_bit = (ones_q > CNT_W'(VOTE_COUNT / 2));
    assign unstable = (ones_q != '0) && (ones_q != CNT_W'(VOTE_COUNT));

endmodule

// File: rtl/puf_majority_voter.sv
// -----------------------------------------------------------------------------
// puf_majority_voter
// Samples the raw PUF response VOTE_COUNT times, majority-votes each bit and
// presents the stabilised signature to the error corrector with a level valid
// held until pcm_ack. Also reports how many bits were not unanimous.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   start, ipid_number_in    : begin a vote for the given IP ID (IDLE only)
//   raw_puf_req              : one-cycle request for a raw PUF response
//   raw_puf_data/_valid      : raw response (accepted only in WAIT)
//   pcm_puf_in/_valid        : voted signature, valid held until pcm_ack
//   pcm_ipid_number          : IP ID captured with start
//   pcm_ack                  : consumer handshake (HOLD only)
//   busy                     : high in every state except IDLE
//   unstable_bits            : non-unanimous bit count of the last vote
//   timeout_err              : one-cycle pulse on watchdog expiry
// Build option: define PUF_VOTER_TIMEOUT_EN to add the WAIT watchdog
// (TIMEOUT_CYCLES); otherwise timeout_err is constant 0.
// -----------------------------------------------------------------------------
`ifndef IPID_WIDTH
`define IPID_WIDTH 32
`endif
`ifndef IPID_N
`define IPID_N 4
`endif

module puf_majority_voter
    import mcse_puf_pkg::*;
#(
    parameter int PUF_SIG_LENGTH = `IPID_WIDTH,
    parameter int IPID_N         = `IPID_N,
    parameter int VOTE_COUNT     = 5,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [$clog2(IPID_N)-1:0]            ipid_number_in,
    output logic                                 raw_puf_req,
    input  logic [PUF_SIG_LENGTH-1:0]            raw_puf_data,
    input  logic                                 raw_puf_valid,
    output logic [PUF_SIG_LENGTH-1:0]            pcm_puf_in,
    output logic                                 pcm_puf_in_valid,
    output logic [$clog2(IPID_N)-1:0]            pcm_ipid_number,
    input  logic                                 pcm_ack,
    output logic                                 busy,
    output logic [$clog2(PUF_SIG_LENGTH+1)-1:0]  unstable_bits,
    output logic                                 timeout_err
);

    localparam int CNT_W = vote_cnt_w(VOTE_COUNT);
    localparam int ID_W  = $clog2(IPID_N);
    localparam int UNS_W = unstable_w(PUF_SIG_LENGTH);

    if (!vote_count_legal(VOTE_COUNT)) begin : g_bad_vote_count
        $fatal(1, "puf_majority_voter: VOTE_COUNT must be odd and within 3..15");
    end
    if ((PUF_SIG_LENGTH % 16) != 0 || PUF_SIG_LENGTH < 16) begin : g_bad_sig_length
        $fatal(1, "puf_majority_voter: PUF_SIG_LENGTH must be a multiple of 16");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $fatal(1, "puf_majority_voter: TIMEOUT_CYCLES must be at least 1");
    end

    voter_state_t               state_q, state_d;
    logic [CNT_W-1:0]           sample_cnt_q, sample_cnt_d;
    logic [ID_W-1:0]            ipid_q, ipid_d;
    logic [PUF_SIG_LENGTH-1:0]  puf_q, puf_d;
    logic                       valid_q, valid_d;
    logic [UNS_W-1:0]           unstable_q, unstable_d;
    logic                       req_q, req_d;
    logic                       busy_q, busy_d;
    logic                       cnt_clr, cnt_inc;
    logic [PUF_SIG_LENGTH-1:0]  vote_vec, unstable_vec;
    logic [UNS_W-1:0]           unstable_cnt;

    for (genvar gi = 0; gi < PUF_SIG_LENGTH; gi++) begin : g_bit
        bit_vote_counter #(
            .VOTE_COUNT (VOTE_COUNT),
            .CNT_W      (CNT_W)
        ) u_cnt (
            .clk        (clk),
            .rst        (rst),
            .clr        (cnt_clr),
            .inc_en     (cnt_inc),
            .sample_bit (raw_puf_data[gi]),
            .vote_bit   (vote_vec[gi]),
            .unstable   (unstable_vec[gi])
        );
    end

    always_comb begin
        unstable_cnt = '0;
        for (int i = 0; i < PUF_SIG_LENGTH; i++) begin
            unstable_cnt = unstable_cnt + UNS_W'(unstable_vec[i]);
        end
    end

`ifdef PUF_VOTER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            timeout_q, timeout_d;
`endif

    always_comb begin
        state_d      = state_q;
        sample_cnt_d = sample_cnt_q;
        ipid_d       = ipid_q;
        puf_d        = puf_q;
        valid_d      = valid_q;
        unstable_d   = unstable_q;
        req_d        = 1'b0;
        cnt_clr      = 1'b0;
        cnt_inc      = 1'b0;
`ifdef PUF_VOTER_TIMEOUT_EN
        wd_d         = wd_q;
        timeout_d    = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ipid_d       = ipid_number_in;
                    cnt_clr      = 1'b1;
                    sample_cnt_d = '0;
                    req_d        = 1'b1;   // req is registered: high during REQ
                    state_d      = ST_REQ;
                end
            end
            ST_REQ: begin
                // raw_puf_valid is deliberately not looked at here.
`ifdef PUF_VOTER_TIMEOUT_EN
                wd_d    = '0;
`endif
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (raw_puf_valid) begin
                    cnt_inc      = 1'b1;
                    sample_cnt_d = sample_cnt_q + 1'b1;
                    if (sample_cnt_q == CNT_W'(VOTE_COUNT - 1)) begin
                        state_d = ST_VOTE;
                    end else begin
                        req_d   = 1'b1;
                        state_d = ST_REQ;
                    end
                end
`ifdef PUF_VOTER_TIMEOUT_EN
                // Expires at the end of the TIMEOUT_CYCLES-th silent WAIT cycle;
                // the partial counts are simply abandoned (cleared on next start).
                else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
`endif
            end
            ST_VOTE: begin
                puf_d      = vote_vec;
                unstable_d = unstable_cnt;
                valid_d    = 1'b1;
                state_d    = ST_HOLD;
            end
            ST_HOLD: begin
                if (pcm_ack) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            sample_cnt_q <= '0;
            ipid_q       <= '0;
            puf_q        <= '0;
            valid_q      <= 1'b0;
            unstable_q   <= '0;
            req_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            ipid_q       <= ipid_d;
            puf_q        <= puf_d;
            valid_q      <= valid_d;
            unstable_q   <= unstable_d;
            req_q        <= req_d;
            busy_q       <= busy_d;
        end
    end

`ifdef PUF_VOTER_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end
    assign timeout_err = timeout_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign raw_puf_req      = req_q;
    assign pcm_puf_in       = puf_q;
    assign pcm_puf_in_valid = valid_q;
    assign pcm_ipid_number  = ipid_q;
    assign busy             = busy_q;
    assign unstable_bits    = unstable_q;

endmodule

// File: tb/tb_puf_majority_voter.sv
// -----------------------------------------------------------------------------
// tb_puf_majority_voter
// Self-checking bench: directed scenarios plus randomized votes, compared
// against a per-bit counting reference model of the majority vote.
// -----------------------------------------------------------------------------
module tb_puf_majority_voter;

    localparam int W      = 32;
    localparam int IPID_N = 4;
    localparam int VC     = 3;
    localparam int TO     = 16;
    localparam int IDW    = 2;
    localparam int UW     = 6;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [IDW-1:0] ipid_number_in;
    logic           raw_puf_req;
    logic [W-1:0]   raw_puf_data;
    logic           raw_puf_valid;
    logic [W-1:0]   pcm_puf_in;
    logic           pcm_puf_in_valid;
    logic [IDW-1:0] pcm_ipid_number;
    logic           pcm_ack;
    logic           busy;
    logic [UW-1:0]  unstable_bits;
    logic           timeout_err;

    puf_majority_voter #(
        .PUF_SIG_LENGTH (W),
        .IPID_N         (IPID_N),
        .VOTE_COUNT     (VC),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .ipid_number_in   (ipid_number_in),
        .raw_puf_req      (raw_puf_req),
        .raw_puf_data     (raw_puf_data),
        .raw_puf_valid    (raw_puf_valid),
        .pcm_puf_in       (pcm_puf_in),
        .pcm_puf_in_valid (pcm_puf_in_valid),
        .pcm_ipid_number  (pcm_ipid_number),
        .pcm_ack          (pcm_ack),
        .busy             (busy),
        .unstable_bits    (unstable_bits),
        .timeout_err      (timeout_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int vote_no  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and land 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(output bit seen, inout int c);
        for (int n = 0; n < 20 && !raw_puf_req; n++) begin
            step();
            c++;
        end
        seen = raw_puf_req;
    endtask

    // Reference: count ones per bit over all samples; strict majority wins,
    // a bit is unstable unless every sample agreed.
    function automatic void model(input logic [31:0] s[$], output logic [31:0] vote,
                                  output int unst);
        vote = '0;
        unst = 0;
        for (int b = 0; b < 32; b++) begin
            int ones = 0;
            foreach (s[k]) ones += int'(s[k][b]);
            vote[b] = (2 * ones > s.size());
            if (ones != 0 && ones != s.size()) unst++;
        end
    endfunction

    // Runs one full vote with a PUF answering l cycles after each request.
    // If stray is set, a bogus all-ones valid is also driven during the first
    // REQ cycle (same cycle as raw_puf_req).
    task automatic run_vote(input logic [31:0] s[$], input int ipid, input int l,
                            input bit stray);
        int          c;
        bit          seen;
        logic [31:0] ev;
        int          eu;
        model(s, ev, eu);
        ipid_number_in = IDW'(ipid);
        start = 1'b1;
        step();
        start = 1'b0;
        c = 1;
        check("busy_rise", busy, 1);
        foreach (s[k]) begin
            wait_req(seen, c);
            if (!seen) begin
                check("req_seen", 0, 1);
                return;
            end
            if (stray && k == 0) begin
                raw_puf_valid = 1'b1;
                raw_puf_data  = '1;
            end
            repeat (l) begin
                step();
                c++;
                raw_puf_valid = 1'b0;
            end
            raw_puf_valid = 1'b1;
            raw_puf_data  = s[k];
            step();
            c++;
            raw_puf_valid = 1'b0;
            raw_puf_data  = $urandom;
        end
        for (int n = 0; n < 20 && !pcm_puf_in_valid; n++) begin
            step();
            c++;
        end
        check("latency", c, 1 + VC * (1 + l) + 1);
        check("signature", pcm_puf_in, ev);
        check("unstable", unstable_bits, eu);
        check("ipid", pcm_ipid_number, ipid);
        vote_no++;
        $display("vote %0d: ipid=%0d L=%0d stray=%0d sig=0x%08h exp=0x%08h unstable=%0d exp=%0d lat=%0d",
                 vote_no, ipid, l, stray, pcm_puf_in, ev, unstable_bits, eu, c);
    endtask

    task automatic ack();
        pcm_ack = 1'b1;
        step();
        pcm_ack = 1'b0;
        check("ack_valid_low", pcm_puf_in_valid, 0);
        check("ack_busy_low", busy, 0);
    endtask

    initial begin
        logic [31:0] smp[$];
        logic [31:0] base;
        int          c;
        int          hold_cnt;
        bit          seen;

        rst = 1'b1; start = 1'b0; ipid_number_in = '0; raw_puf_valid = 1'b0;
        raw_puf_data = '0; pcm_ack = 1'b0;
        step();
        step();
        check("rst_valid", pcm_puf_in_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sig", pcm_puf_in, 0);
        check("rst_ipid", pcm_ipid_number, 0);
        check("rst_unstable", unstable_bits, 0);
        check("rst_req", raw_puf_req, 0);
        check("rst_timeout", timeout_err, 0);
        rst = 1'b0;
        step();

        // Stable PUF
        smp = '{32'hA5A5_F00F, 32'hA5A5_F00F, 32'hA5A5_F00F};
        run_vote(smp, 2, 1, 1'b0);

        // Hold with no ack; a start during HOLD must be ignored
        start = 1'b1; ipid_number_in = 2'd3;
        step();
        start = 1'b0;
        hold_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            hold_cnt += int'(pcm_puf_in_valid);
        end
        check("hold_valid", hold_cnt, 20);
        check("hold_ipid", pcm_ipid_number, 2);
        check("hold_busy", busy, 1);
        ack();
        check("persist_sig", pcm_puf_in, 32'hA5A5_F00F);
        check("persist_ipid", pcm_ipid_number, 2);

        // Noisy PUF, started on the very cycle after the ack took effect
        smp = '{32'h0000_00FF, 32'h0000_00F0, 32'h0000_000F};
        run_vote(smp, 1, 1, 1'b0);
        ack();
        check("persist_unstable", unstable_bits, 8);

        // Reset in the middle of a vote (two all-ones samples, then reset)
        ipid_number_in = 2'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        c = 1;
        for (int k = 0; k < 2; k++) begin
            wait_req(seen, c);
            check("mid_req_seen", seen, 1);
            step();
            raw_puf_valid = 1'b1;
            raw_puf_data  = '1;
            step();
            raw_puf_valid = 1'b0;
        end
        rst = 1'b1;
        step();
        check("mid_rst_valid", pcm_puf_in_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_sig", pcm_puf_in, 0);
        check("mid_rst_ipid", pcm_ipid_number, 0);
        check("mid_rst_unstable", unstable_bits, 0);
        check("mid_rst_req", raw_puf_req, 0);
        rst = 1'b0;
        step();
        smp = '{32'h00FF_00FF, 32'h00FF_00FF, 32'h0000_0000};
        run_vote(smp, 1, 2, 1'b0);
        ack();

        // Stray valid in IDLE and in REQ, followed by an all-zero vote
        raw_puf_valid = 1'b1;
        raw_puf_data  = '1;
        step();
        raw_puf_valid = 1'b0;
        check("stray_idle_busy", busy, 0);
        smp = '{32'h0, 32'h0, 32'h0};
        run_vote(smp, 0, 1, 1'b1);
        ack();

        // Randomized votes: mostly-stable PUF with sparse bit noise
        for (int t = 0; t < 30; t++) begin
            base = $urandom;
            smp.delete();
            for (int k = 0; k < VC; k++) begin
                smp.push_back(base ^ ($urandom & $urandom & $urandom));
            end
            run_vote(smp, int'($urandom_range(0, 3)), int'($urandom_range(1, 3)),
                     1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) step();
            ack();
        end

        // Silent PUF
        ipid_number_in = 2'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        c = 1;
        wait_req(seen, c);
        check("silent_req_seen", seen, 1);
        begin
            int first = 0;
            int pulses = 0;
            int seen_valid = 0;
            for (int n = 1; n <= 40; n++) begin
                step();
                if (timeout_err) begin
                    pulses++;
                    if (first == 0) first = n;
                end
                if (pcm_puf_in_valid) seen_valid++;
            end
`ifdef PUF_VOTER_TIMEOUT_EN
            // 16 silent WAIT cycles, pulse visible on the following cycle
            check("to_delay", first, TO + 1);
            check("to_pulses", pulses, 1);
            check("to_valid", seen_valid, 0);
            check("to_busy", busy, 0);
`else
            check("no_to_pulses", pulses, 0);
            check("no_to_valid", seen_valid, 0);
            check("no_to_busy", busy, 1);
            rst = 1'b1;
            step();
            rst = 1'b0;
            check("no_to_rst_busy", busy, 0);
`endif
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
